// File: rtl/dsp_share_ctrl.sv
// Round-robin share of one pipelined DSP slice (P = A*(D+/-B) +/- C) between two requesters.
// Accept-to-result latency LATENCY+2; no result backpressure; flush quiesces the slice.
module dsp_share_ctrl #(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [17:0]       r0_a,
  input  logic [17:0]       r0_b,
  input  logic [17:0]       r0_d,
  input  logic [47:0]       r0_c,
  input  logic              r0_sub,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [17:0]       r1_a,
  input  logic [17:0]       r1_b,
  input  logic [17:0]       r1_d,
  input  logic [47:0]       r1_c,
  input  logic              r1_sub,
  output logic [17:0]       dsp_a,
  output logic [17:0]       dsp_b,
  output logic [17:0]       dsp_d,
  output logic [47:0]       dsp_c,
  output logic              dsp_sub,
  output logic              dsp_in_valid,
  input  logic [47:0]       dsp_p,
  output logic              r0_res_valid,
  output logic              r1_res_valid,
  output logic [47:0]       res_p,
  input  logic              flush,
  output logic              flush_done,
  output logic              busy,
  output logic [CNT_W-1:0]  r0_cnt,
  output logic [CNT_W-1:0]  r1_cnt
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              flush_done_q, flush_done_d;
  logic              last_q, last_d;
  logic [17:0]       dsp_a_q, dsp_a_d;
  logic [17:0]       dsp_b_q, dsp_b_d;
  logic [17:0]       dsp_d_q, dsp_d_d;
  logic [47:0]       dsp_c_q, dsp_c_d;
  logic              dsp_sub_q, dsp_sub_d;
  logic              dsp_vld_q;
  logic [LATENCY:0]  tag_vld_q;
  logic [LATENCY:0]  tag_own_q;
  logic              res0_q, res1_q;
  logic [47:0]       res_p_q, res_p_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;
  logic              gnt0, gnt1;
  logic              xfer0, xfer1, xfer;
  logic              busy_w;

  // last_q names the requester granted most recently; ties go to the other one.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == RUN) begin
      if (r0_valid && (!r1_valid || last_q)) begin
        gnt0 = 1'b1;
      end else if (r1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign xfer0  = r0_valid & gnt0;
  assign xfer1  = r1_valid & gnt1;
  assign xfer   = xfer0 | xfer1;
  assign busy_w = dsp_vld_q | (|tag_vld_q);

  always_comb begin
    dsp_a_d   = dsp_a_q;
    dsp_b_d   = dsp_b_q;
    dsp_d_d   = dsp_d_q;
    dsp_c_d   = dsp_c_q;
    dsp_sub_d = dsp_sub_q;
    last_d    = last_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    if (xfer0) begin
      dsp_a_d   = r0_a;
      dsp_b_d   = r0_b;
      dsp_d_d   = r0_d;
      dsp_c_d   = r0_c;
      dsp_sub_d = r0_sub;
      last_d    = 1'b0;
      cnt0_d    = cnt0_q + CNT_W'(1);
    end else if (xfer1) begin
      dsp_a_d   = r1_a;
      dsp_b_d   = r1_b;
      dsp_d_d   = r1_d;
      dsp_c_d   = r1_c;
      dsp_sub_d = r1_sub;
      last_d    = 1'b1;
      cnt1_d    = cnt1_q + CNT_W'(1);
    end
  end

  always_comb begin
    res_p_d = res_p_q;
    if (tag_vld_q[LATENCY]) begin
      res_p_d = dsp_p;
    end
  end

  // Drain completes once nothing is issued or in flight; done is registered so it trails the last result.
  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!busy_w) begin
          state_d      = RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
      last_q       <= 1'b1;
      dsp_a_q      <= '0;
      dsp_b_q      <= '0;
      dsp_d_q      <= '0;
      dsp_c_q      <= '0;
      dsp_sub_q    <= 1'b0;
      dsp_vld_q    <= 1'b0;
      tag_vld_q    <= '0;
      tag_own_q    <= '0;
      res0_q       <= 1'b0;
      res1_q       <= 1'b0;
      res_p_q      <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
      last_q       <= last_d;
      dsp_a_q      <= dsp_a_d;
      dsp_b_q      <= dsp_b_d;
      dsp_d_q      <= dsp_d_d;
      dsp_c_q      <= dsp_c_d;
      dsp_sub_q    <= dsp_sub_d;
      dsp_vld_q    <= xfer;
      tag_vld_q    <= {tag_vld_q[LATENCY-1:0], xfer};
      tag_own_q    <= {tag_own_q[LATENCY-1:0], xfer1};
      res0_q       <= tag_vld_q[LATENCY] & ~tag_own_q[LATENCY];
      res1_q       <= tag_vld_q[LATENCY] & tag_own_q[LATENCY];
      res_p_q      <= res_p_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign r0_ready     = gnt0;
  assign r1_ready     = gnt1;
  assign dsp_a        = dsp_a_q;
  assign dsp_b        = dsp_b_q;
  assign dsp_d        = dsp_d_q;
  assign dsp_c        = dsp_c_q;
  assign dsp_sub      = dsp_sub_q;
  assign dsp_in_valid = dsp_vld_q;
  assign r0_res_valid = res0_q;
  assign r1_res_valid = res1_q;
  assign res_p        = res_p_q;
  assign flush_done   = flush_done_q;
  assign busy         = busy_w;
  assign r0_cnt       = cnt0_q;
  assign r1_cnt       = cnt1_q;

endmodule

// File: tb/tb_dsp_share_ctrl.sv
// Bench for dsp_share_ctrl: behavioural DSP model, scoreboard keyed by due cycle, directed and random traffic.
module tb_dsp_share_ctrl;
  localparam int LATENCY = 3;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic r0_valid, r0_ready, r0_sub, r1_valid, r1_ready, r1_sub;
  logic [17:0] r0_a, r0_b, r0_d, r1_a, r1_b, r1_d;
  logic [47:0] r0_c, r1_c;
  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c, dsp_p, res_p;
  logic dsp_sub, dsp_in_valid, r0_res_valid, r1_res_valid;
  logic flush, flush_done, busy;
  logic [CNT_W-1:0] r0_cnt, r1_cnt;

  dsp_share_ctrl #(.LATENCY(LATENCY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_d(r0_d),
    .r0_c(r0_c), .r0_sub(r0_sub),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_d(r1_d),
    .r1_c(r1_c), .r1_sub(r1_sub),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c), .dsp_sub(dsp_sub),
    .dsp_in_valid(dsp_in_valid), .dsp_p(dsp_p),
    .r0_res_valid(r0_res_valid), .r1_res_valid(r1_res_valid), .res_p(res_p),
    .flush(flush), .flush_done(flush_done), .busy(busy),
    .r0_cnt(r0_cnt), .r1_cnt(r1_cnt)
  );

  function automatic logic [47:0] dsp_f(input logic [17:0] a, input logic [17:0] b,
                                        input logic [17:0] d, input logic [47:0] c,
                                        input logic sub);
    longint sa, sb, sd, sc, pre, r;
    sa = $signed(a);
    sb = $signed(b);
    sd = $signed(d);
    sc = $signed(c);
    pre = sub ? (sd - sb) : (sd + sb);
    r = sub ? (sa * pre - sc) : (sa * pre + sc);
    return r[47:0];
  endfunction

  // The slice itself: LATENCY register stages after the operand registers.
  logic [47:0] p_pipe [LATENCY];
  always @(posedge clk) begin
    p_pipe[0] <= dsp_f(dsp_a, dsp_b, dsp_d, dsp_c, dsp_sub);
    for (int i = 1; i < LATENCY; i++) p_pipe[i] <= p_pipe[i-1];
  end
  assign dsp_p = p_pipe[LATENCY-1];

  typedef struct { int owner; logic [47:0] p; int due; } exp_t;
  exp_t sbq[$];

  int  errors = 0, checks = 0, cyc = 0;
  int  m_cnt[2];
  bit  m_drain, m_last, m_fd, m_prev_acc;
  int  last_res_cyc = -1, fd_cyc = -1, fd_count = 0, res_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    sbq.delete();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_drain = 0; m_last = 1; m_fd = 0; m_prev_acc = 0;
  endtask

  // Evaluated mid-cycle (negedge): compare everything, then account for this cycle's transfer.
  task automatic model_eval();
    bit e0, e1, acc, own, er0, er1, busy_e;
    logic [47:0] ep;
    exp_t e;
    e0 = 0; e1 = 0; er0 = 0; er1 = 0; ep = '0;
    if (!m_drain) begin
      case ({r0_valid, r1_valid})
        2'b10: e0 = 1;
        2'b01: e1 = 1;
        2'b11: if (m_last) e0 = 1; else e1 = 1;
        default: ;
      endcase
    end
    chk("r0_ready", r0_ready, e0);
    chk("r1_ready", r1_ready, e1);
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      er0 = (e.owner == 0);
      er1 = (e.owner == 1);
      ep = e.p;
    end
    chk("r0_res_valid", r0_res_valid, er0);
    chk("r1_res_valid", r1_res_valid, er1);
    if (er0 || er1) chk("res_p", res_p, ep);
    if (r0_res_valid || r1_res_valid) begin
      last_res_cyc = cyc;
      res_count++;
    end
    busy_e = (sbq.size() > 0);
    chk("busy", busy, busy_e);
    chk("dsp_in_valid", dsp_in_valid, m_prev_acc);
    chk("flush_done", flush_done, m_fd);
    if (flush_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
    chk("r0_cnt", r0_cnt, m_cnt[0]);
    chk("r1_cnt", r1_cnt, m_cnt[1]);
    acc = (e0 && r0_valid) || (e1 && r1_valid);
    own = e1;
    if (acc) begin
      e.owner = own;
      e.p = own ? dsp_f(r1_a, r1_b, r1_d, r1_c, r1_sub) : dsp_f(r0_a, r0_b, r0_d, r0_c, r0_sub);
      e.due = cyc + LATENCY + 2;
      sbq.push_back(e);
      m_cnt[own] = (m_cnt[own] + 1) % (1 << CNT_W);
      m_last = own;
    end
    m_fd = 0;
    if (!m_drain && flush) m_drain = 1;
    else if (m_drain && !busy_e) begin
      m_drain = 0;
      m_fd = 1;
    end
    m_prev_acc = acc;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    adv();
  endtask

  task automatic do_reset();
    rst = 1; r0_valid = 0; r1_valid = 0; flush = 0;
    @(negedge clk);
    adv();
    rst = 0;
    model_clear();
  endtask

  task automatic set_ops(input int owner, input logic [17:0] a, input logic [17:0] d,
                         input logic [17:0] b, input logic [47:0] c, input logic sub);
    if (owner == 0) begin r0_a = a; r0_d = d; r0_b = b; r0_c = c; r0_sub = sub; end
    else            begin r1_a = a; r1_d = d; r1_b = b; r1_c = c; r1_sub = sub; end
  endtask

  task automatic run_single(input int owner, input logic sub, input logic [47:0] exp_p);
    bit hit;
    set_ops(owner, 18'd3, 18'd5, 18'd2, 48'd10, sub);
    if (owner == 0) r0_valid = 1; else r1_valid = 1;
    step();
    r0_valid = 0; r1_valid = 0;
    for (int k = 1; k <= LATENCY + 3; k++) begin
      @(negedge clk);
      hit = (k == LATENCY + 2);
      chk("single_r0_strobe", r0_res_valid, hit && owner == 0);
      chk("single_r1_strobe", r1_res_valid, hit && owner == 1);
      if (hit) chk("single_res_p", res_p, exp_p);
      model_eval();
      adv();
    end
    chk("single_cnt", owner == 0 ? r0_cnt : r1_cnt, 1);
  endtask

  typedef struct { logic v0, v1, rdy0, rdy1, res0, res1; logic [47:0] p; } vec_t;
  vec_t vt [12];

  initial begin
    int rc0, fd0, start;
    vt[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 48'd0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 48'd0};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 48'd0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 48'd0};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 48'd0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 48'd12};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 48'd12};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 48'd12};
    vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF};
    vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 48'd0};

    set_ops(0, '0, '0, '0, '0, 1'b0);
    set_ops(1, '0, '0, '0, '0, 1'b0);
    do_reset();
    chk("rst_dsp_a", dsp_a, 0);
    chk("rst_dsp_c", dsp_c, 0);
    chk("rst_res_p", res_p, 0);
    chk("rst_dsp_in_valid", dsp_in_valid, 0);
    chk("rst_flush_done", flush_done, 0);

    // Single add and single subtract.
    run_single(0, 1'b0, 48'd31);
    do_reset();
    run_single(1, 1'b1, 48'hFFFF_FFFF_FFFF);

    // Contention table.
    do_reset();
    set_ops(0, 18'd2, 18'd3, 18'd1, 48'd4, 1'b0);
    set_ops(1, 18'd3, 18'd5, 18'd2, 48'd10, 1'b1);
    for (int i = 0; i < 12; i++) begin
      r0_valid = vt[i].v0;
      r1_valid = vt[i].v1;
      @(negedge clk);
      chk("tbl_rdy0", r0_ready, vt[i].rdy0);
      chk("tbl_rdy1", r1_ready, vt[i].rdy1);
      chk("tbl_res0", r0_res_valid, vt[i].res0);
      chk("tbl_res1", r1_res_valid, vt[i].res1);
      if (vt[i].res0 || vt[i].res1) chk("tbl_res_p", res_p, vt[i].p);
      model_eval();
      adv();
    end
    chk("tbl_cnt0", r0_cnt, 3);
    chk("tbl_cnt1", r1_cnt, 3);

    // Flush with the fourth of four back-to-back transfers.
    do_reset();
    set_ops(0, 18'd7, 18'd11, 18'd3, 48'd100, 1'b0);
    fd0 = fd_count; rc0 = res_count; start = cyc;
    for (int i = 0; i < 4; i++) begin
      r0_valid = 1; flush = (i == 3);
      step();
    end
    flush = 0;
    step();
    step();
    r0_valid = 0;
    for (int i = 0; i < 10; i++) step();
    chk("flush_done_count", fd_count - fd0, 1);
    chk("flush_done_after_last_res", fd_cyc - last_res_cyc, 1);
    chk("flush_done_cycle", fd_cyc - start, LATENCY + 6);
    chk("flush_results", res_count - rc0, 4);
    r0_valid = 1;
    step();
    r0_valid = 0;
    for (int i = 0; i < LATENCY + 3; i++) step();

    // Reset two cycles after a transfer.
    do_reset();
    set_ops(1, 18'd9, 18'd9, 18'd9, 48'd9, 1'b0);
    r1_valid = 1;
    step();
    r1_valid = 0;
    step();
    rc0 = res_count;
    do_reset();
    for (int i = 0; i < LATENCY + 4; i++) step();
    chk("rst_flight_no_res", res_count - rc0, 0);
    chk("rst_flight_cnt0", r0_cnt, 0);
    chk("rst_flight_cnt1", r1_cnt, 0);
    run_single(0, 1'b0, 48'd31);

    // Counter wrap.
    do_reset();
    r0_valid = 1;
    for (int i = 0; i < 17; i++) step();
    r0_valid = 0;
    chk("cnt_wrap", r0_cnt, 1);
    for (int i = 0; i < LATENCY + 3; i++) step();

    // Random traffic with occasional flushes.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r0_valid = ($urandom_range(0, 2) != 0);
      r1_valid = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      set_ops(0, 18'($urandom), 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}), 1'($urandom));
      set_ops(1, 18'($urandom), 18'($urandom), 18'($urandom), 48'({$urandom, $urandom}), 1'($urandom));
      step();
    end
    r0_valid = 0; r1_valid = 0; flush = 0;
    for (int i = 0; i < LATENCY + 6; i++) step();
    chk("random_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

endmodule
